// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial equality comparator.
//   state_t : FSM state encoding (IDLE / SHIFT / DONE)
//   cw_of() : width of counters and indices able to hold 0..width
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_eq_cmp_if.sv
// Handshake and result bundle of serial_eq_cmp.
//   master : drives start / bit_valid / a_bit / b_bit, receives results
//   slave  : the comparator side
//   start, bit_valid, a_bit, b_bit : request side (1 bit each)
//   busy, done, equal              : status (1 bit each)
//   mismatch_cnt, first_idx        : results, CW bits each
interface serial_eq_cmp_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  localparam int CW = cw_of(WIDTH);

  logic          start;
  logic          bit_valid;
  logic          a_bit;
  logic          b_bit;
  logic          busy;
  logic          done;
  logic          equal;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] first_idx;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, equal, mismatch_cnt, first_idx
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, equal, mismatch_cnt, first_idx
  );

endinterface

// File: rtl/serial_eq_cmp_xnor_nand.sv
// 1-bit equivalence s = ~(a ^ b) built purely from two-input NAND gates.
//   s : out, 1 when a and b are equal
//   a : in, operand bit
//   b : in, operand bit
module xnor_nand (
  output logic s,
  input  logic a,
  input  logic b
);

  logic n_ab;
  logic n_a;
  logic n_b;
  logic x_ab;

  // Classic four-NAND XOR, then a NAND wired as inverter for the XNOR.
  nand g_ab (n_ab, a, b);
  nand g_a  (n_a, a, n_ab);
  nand g_b  (n_b, b, n_ab);
  nand g_x  (x_ab, n_a, n_b);
  nand g_s  (s, x_ab, x_ab);

endmodule

// File: rtl/serial_eq_cmp.sv
// Bit-serial word equality comparator. Takes one (a_bit, b_bit) pair per
// cycle with bit_valid, LSB first, for WIDTH pairs; then pulses done and
// presents equality, mismatch count and index of the first mismatch.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_eq_cmp_if slave (start, bit_valid, a_bit, b_bit in;
//           busy, done, equal, mismatch_cnt, first_idx out)
module serial_eq_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_eq_cmp_if.slave  bus
);

  localparam int CW = cw_of(WIDTH);
  localparam logic [CW-1:0] NO_MISS  = CW'(WIDTH);      // "no mismatch" code
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t        state_reg,        state_next;
  logic [CW-1:0] bit_cnt_reg,      bit_cnt_next;
  logic [CW-1:0] mismatch_cnt_reg, mismatch_cnt_next;
  logic [CW-1:0] first_idx_reg,    first_idx_next;
  logic          eq_acc_reg,       eq_acc_next;
  logic          equal_reg,        equal_next;
  logic          eq;

  xnor_nand u_eq (
    .s (eq),
    .a (bus.a_bit),
    .b (bus.b_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      bit_cnt_reg      <= '0;
      mismatch_cnt_reg <= '0;
      first_idx_reg    <= '0;
      eq_acc_reg       <= 1'b0;
      equal_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      mismatch_cnt_reg <= mismatch_cnt_next;
      first_idx_reg    <= first_idx_next;
      eq_acc_reg       <= eq_acc_next;
      equal_reg        <= equal_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    mismatch_cnt_next = mismatch_cnt_reg;
    first_idx_next    = first_idx_reg;
    eq_acc_next       = eq_acc_reg;
    equal_next        = equal_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        // bit_valid is ignored here, even alongside start.
        if (bus.start) begin
          state_next        = S_SHIFT;
          bit_cnt_next      = '0;
          mismatch_cnt_next = '0;
          first_idx_next    = NO_MISS;
          eq_acc_next       = 1'b1;
          equal_next        = 1'b0;  // equal reads 0 while shifting
        end else if (state_reg == S_DONE) begin
          state_next = S_IDLE;
        end
      end

      S_SHIFT: begin
        if (bus.bit_valid) begin
          if (!eq) begin
            mismatch_cnt_next = mismatch_cnt_reg + 1'b1;
            eq_acc_next       = 1'b0;
            if (first_idx_reg == NO_MISS) begin
              first_idx_next = bit_cnt_reg;
            end
          end
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = S_DONE;
            // Fold in the last pair now so equal is valid during the done cycle.
            equal_next = eq_acc_reg & eq;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.busy         = (state_reg == S_SHIFT);
  assign bus.done         = (state_reg == S_DONE);
  assign bus.equal        = equal_reg;
  assign bus.mismatch_cnt = mismatch_cnt_reg;
  assign bus.first_idx    = first_idx_reg;

endmodule
